// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for the 16-bit MIPS core: sequences fetch, decode,
// execute, memory and writeback, with a timed req/ready memory handshake.
module multicycle_ctrl #(
    parameter logic [2:0] ALUOP_RTYPE = 3'b001,
    parameter logic [2:0] ALUOP_ADD   = 3'b010,
    parameter logic [2:0] ALUOP_SUB   = 3'b110,
    parameter int         TMO_W       = 4,
    parameter int         MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] AluOp,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic [3:0] state,
    output logic       fault
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        WB_R     = 4'd4,
        EXEC_I   = 4'd5,
        WB_I     = 4'd6,
        MEM_ADDR = 4'd7,
        MEM_RD   = 4'd8,
        MEM_WB   = 4'd9,
        MEM_WR   = 4'd10,
        BRANCH   = 4'd11,
        JUMP     = 4'd12,
        FAULT    = 4'd13
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);

    state_t           state_r;
    state_t           state_s;
    logic [TMO_W-1:0] wait_cnt_r;
    logic [TMO_W-1:0] wait_cnt_s;
    logic             wait_state_s;
    logic             timeout_s;

    assign wait_state_s = (state_r == FETCH) || (state_r == MEM_RD) || (state_r == MEM_WR);
    // A completing access in the limit cycle wins over the timeout.
    assign timeout_s    = wait_state_s && !mem_ready && (wait_cnt_r == TMO_LIM);
    assign state        = state_r;

    // State and memory-wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            wait_cnt_r <= {TMO_W{1'b0}};
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Wait counter: counts stalled cycles in memory states, zero everywhere else.
    always_comb begin
        wait_cnt_s = {TMO_W{1'b0}};
        if (wait_state_s && !mem_ready && !timeout_s) begin
            wait_cnt_s = wait_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_s = {TMO_W{1'b0}};
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:     state_s = FETCH;
            FETCH: begin
                if (mem_ready)      state_s = DECODE;
                else if (timeout_s) state_s = FAULT;
                else                state_s = FETCH;
            end
            DECODE: begin
                case (opcode)
                    4'b0000: state_s = EXEC_R;
                    4'b0001: state_s = EXEC_I;
                    4'b0010: state_s = MEM_ADDR;
                    4'b0011: state_s = MEM_ADDR;
                    4'b0100: state_s = BRANCH;
                    4'b0101: state_s = JUMP;
                    default: state_s = FAULT;
                endcase
            end
            EXEC_R:   state_s = WB_R;
            WB_R:     state_s = FETCH;
            EXEC_I:   state_s = WB_I;
            WB_I:     state_s = FETCH;
            MEM_ADDR: begin
                if (opcode == 4'b0010) state_s = MEM_RD;
                else                   state_s = MEM_WR;
            end
            MEM_RD: begin
                if (mem_ready)      state_s = MEM_WB;
                else if (timeout_s) state_s = FAULT;
                else                state_s = MEM_RD;
            end
            MEM_WB:   state_s = FETCH;
            MEM_WR: begin
                if (mem_ready)      state_s = FETCH;
                else if (timeout_s) state_s = FAULT;
                else                state_s = MEM_WR;
            end
            BRANCH:   state_s = FETCH;
            JUMP:     state_s = FETCH;
            FAULT:    state_s = FAULT;
            default:  state_s = FAULT;
        endcase
    end

    // Output decode from the registered state; only fetch/store completion looks at mem_ready.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        AluOp         = 3'b000;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        instr_done    = 1'b0;
        fault         = 1'b0;
        case (state_r)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                AluOp     = ALUOP_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                AluOp     = ALUOP_ADD;
            end
            EXEC_R: begin
                alu_src_a = 1'b1;
                AluOp     = ALUOP_RTYPE;
            end
            WB_R: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            EXEC_I, MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                AluOp     = ALUOP_ADD;
            end
            WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                AluOp         = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
                instr_done    = 1'b1;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            FAULT:   fault = 1'b1;
            default: fault = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction sequences with a
// scoreboard of expected state/control vectors derived from the control table.
module tb_multicycle_ctrl;

    localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,
                           S_EXEC_R = 4'd3, S_WB_R = 4'd4,  S_EXEC_I = 4'd5,
                           S_WB_I = 4'd6,  S_MEM_ADDR = 4'd7, S_MEM_RD = 4'd8,
                           S_MEM_WB = 4'd9, S_MEM_WR = 4'd10, S_BRANCH = 4'd11,
                           S_JUMP = 4'd12, S_FAULT = 4'd13;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       mem_ready = 1'b1;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src, alu_src_b;
    logic       alu_src_a;
    logic [2:0] AluOp;
    logic       reg_write, reg_dst, mem_to_reg, instr_done, fault;
    logic [3:0] state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [22:0] sb_q[$];

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .AluOp(AluOp), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done), .state(state),
        .fault(fault)
    );

    always #5 clk = ~clk;

    logic [18:0] outs_s;
    assign outs_s = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                     pc_src, alu_src_a, alu_src_b, AluOp, reg_write, reg_dst,
                     mem_to_reg, instr_done, fault};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Expected control vector from the control table for a given state and mem_ready.
    function automatic logic [18:0] exp_outs(input logic [3:0] st, input logic rdy);
        logic mr = 1'b0, mw = 1'b0, iod = 1'b0, irw = 1'b0, pcw = 1'b0, pcc = 1'b0;
        logic [1:0] psrc = 2'b00, srcb = 2'b00;
        logic srca = 1'b0, rw = 1'b0, rd = 1'b0, m2r = 1'b0, dn = 1'b0, flt = 1'b0;
        logic [2:0] op = 3'b000;
        case (st)
            S_FETCH:  begin mr = 1'b1; srcb = 2'b01; op = 3'b010; irw = rdy; pcw = rdy; end
            S_DECODE: begin srcb = 2'b11; op = 3'b010; end
            S_EXEC_R: begin srca = 1'b1; srcb = 2'b00; op = 3'b001; end
            S_WB_R:   begin rd = 1'b1; rw = 1'b1; dn = 1'b1; end
            S_EXEC_I, S_MEM_ADDR: begin srca = 1'b1; srcb = 2'b10; op = 3'b010; end
            S_WB_I:   begin rw = 1'b1; dn = 1'b1; end
            S_MEM_RD: begin mr = 1'b1; iod = 1'b1; end
            S_MEM_WB: begin m2r = 1'b1; rw = 1'b1; dn = 1'b1; end
            S_MEM_WR: begin mw = 1'b1; iod = 1'b1; dn = rdy; end
            S_BRANCH: begin srca = 1'b1; op = 3'b110; pcc = 1'b1; psrc = 2'b01; dn = 1'b1; end
            S_JUMP:   begin psrc = 2'b10; pcw = 1'b1; dn = 1'b1; end
            S_FAULT:  flt = 1'b1;
            default:  flt = 1'b0;
        endcase
        return {mr, mw, iod, irw, pcw, pcc, psrc, srca, srcb, op, rw, rd, m2r, dn, flt};
    endfunction

    // One clock: drive inputs, queue the expectation, compare on the falling edge.
    task automatic cyc(input logic rdy, input logic [3:0] op, input logic [3:0] exp_st);
        logic [22:0] e;
        mem_ready = rdy;
        opcode    = op;
        sb_q.push_back({exp_st, exp_outs(exp_st, rdy)});
        @(negedge clk);
        e = sb_q.pop_front();
        chk("state", 32'(state), 32'(e[22:19]));
        chk("ctrl", 32'(outs_s), 32'(e[18:0]));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_ctrl", 32'(outs_s), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        mem_ready = 1'b1;
        opcode    = 4'd0;
        @(posedge clk);
        #1;
        do_reset();
        // R-type, zero wait
        cyc(1'b1, 4'b0000, S_IDLE);
        cyc(1'b1, 4'b0000, S_FETCH);
        cyc(1'b1, 4'b0000, S_DECODE);
        cyc(1'b1, 4'b0000, S_EXEC_R);
        cyc(1'b1, 4'b0000, S_WB_R);
        // addi, mem_ready low outside memory states is ignored
        cyc(1'b1, 4'b0001, S_FETCH);
        cyc(1'b0, 4'b0001, S_DECODE);
        cyc(1'b0, 4'b0001, S_EXEC_I);
        cyc(1'b0, 4'b0001, S_WB_I);
        // lw with three wait cycles: 8 cycles FETCH to FETCH
        cyc(1'b1, 4'b0010, S_FETCH);
        cyc(1'b1, 4'b0010, S_DECODE);
        cyc(1'b1, 4'b0010, S_MEM_ADDR);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0010, S_MEM_RD);
        cyc(1'b1, 4'b0010, S_MEM_RD);
        cyc(1'b1, 4'b0010, S_MEM_WB);
        // sw zero wait
        cyc(1'b1, 4'b0011, S_FETCH);
        cyc(1'b1, 4'b0011, S_DECODE);
        cyc(1'b1, 4'b0011, S_MEM_ADDR);
        cyc(1'b1, 4'b0011, S_MEM_WR);
        // beq and j
        cyc(1'b1, 4'b0100, S_FETCH);
        cyc(1'b1, 4'b0100, S_DECODE);
        cyc(1'b1, 4'b0100, S_BRANCH);
        cyc(1'b1, 4'b0101, S_FETCH);
        cyc(1'b1, 4'b0101, S_DECODE);
        cyc(1'b1, 4'b0101, S_JUMP);
        // sw interrupted by reset while the write is pending
        cyc(1'b1, 4'b0011, S_FETCH);
        cyc(1'b1, 4'b0011, S_DECODE);
        cyc(1'b1, 4'b0011, S_MEM_ADDR);
        cyc(1'b0, 4'b0011, S_MEM_WR);
        mem_ready = 1'b0;
        #2;
        chk("wr_pending", 32'(mem_write), 32'd1);
        do_reset();
        cyc(1'b0, 4'b0011, S_IDLE);
        // fetch timeout: 16 stalled cycles
        for (int i = 0; i < 16; i++) cyc(1'b0, 4'b0000, S_FETCH);
        cyc(1'b0, 4'b0000, S_FAULT);
        do_reset();
        // ready arrives in the limit cycle: completion wins, then illegal opcode
        cyc(1'b0, 4'b1111, S_IDLE);
        for (int i = 0; i < 15; i++) cyc(1'b0, 4'b1111, S_FETCH);
        cyc(1'b1, 4'b1111, S_FETCH);
        cyc(1'b1, 4'b1111, S_DECODE);
        for (int i = 0; i < 20; i++) cyc(1'(i % 2), 4'(i), S_FAULT);
        do_reset();
        cyc(1'b1, 4'b0000, S_IDLE);
        cyc(1'b1, 4'b0000, S_FETCH);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
